// File: rtl/reg_writeback_arbiter_if.sv
// rtl/reg_writeback_arbiter_if.sv - primary/secondary result, register-file write and decode-check bundle
// master: the arbiter; slave: its environment (pipeline, mul/div, decode, register file).
interface reg_writeback_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          pri_we;
  logic [4:0]    pri_rd;
  logic [31:0]   pri_data;
  logic          sec_valid;
  logic          sec_ready;
  logic [4:0]    sec_rd;
  logic [31:0]   sec_data;
  logic          reg_write;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic [4:0]    chk_rs;
  logic [4:0]    chk_rt;
  logic          rs_pending;
  logic          rt_pending;
  logic          rs_fwd_valid;
  logic          rt_fwd_valid;
  logic [31:0]   rs_fwd_data;
  logic [31:0]   rt_fwd_data;
  logic [AW:0]   fifo_count;

  modport master (
    input  pri_we, pri_rd, pri_data, sec_valid, sec_rd, sec_data, chk_rs, chk_rt,
    output sec_ready, reg_write, write_reg, write_data, rs_pending, rt_pending,
           rs_fwd_valid, rt_fwd_valid, rs_fwd_data, rt_fwd_data, fifo_count
  );

  modport slave (
    output pri_we, pri_rd, pri_data, sec_valid, sec_rd, sec_data, chk_rs, chk_rt,
    input  sec_ready, reg_write, write_reg, write_data, rs_pending, rt_pending,
           rs_fwd_valid, rt_fwd_valid, rs_fwd_data, rt_fwd_data, fifo_count
  );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// rtl/reg_writeback_arbiter.sv - merges primary and FIFO-buffered secondary results onto one register-file write port
// Optional macro WB_FORWARD_EN enables decode forwarding of pending write data.
module reg_writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  reg_writeback_arbiter_if.master        bus
);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_reg_write;
  logic [4:0]    r_write_reg;
  logic [31:0]   r_write_data;

  logic w_pri_eff;
  logic w_sec_ready;
  logic w_push;
  logic w_pop;

  assign w_pri_eff   = bus.pri_we && (bus.pri_rd != 5'd0);
  assign w_sec_ready = (r_count < (AW+1)'(DEPTH)) && rst_n;
  // Results for r0 complete the handshake but are dropped, never queued.
  assign w_push      = bus.sec_valid && w_sec_ready && (bus.sec_rd != 5'd0);
  assign w_pop       = !w_pri_eff && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= bus.sec_rd;
      r_data[r_wptr] <= bus.sec_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      if (w_pri_eff) begin
        r_reg_write  <= 1'b1;
        r_write_reg  <= bus.pri_rd;
        r_write_data <= bus.pri_data;
      end else if (w_pop) begin
        r_reg_write  <= 1'b1;
        r_write_reg  <= r_rd[r_rptr];
        r_write_data <= r_data[r_rptr];
      end else begin
        r_reg_write  <= 1'b0;
        r_write_reg  <= 5'd0;
        r_write_data <= 32'd0;
      end
    end
  end

  function automatic logic lookup_hit(input logic [4:0] chk);
    logic          hit;
    logic [AW-1:0] idx;
    hit = r_reg_write && (r_write_reg == chk);
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rptr + AW'(k);
      if (((AW+1)'(k) < r_count) && (r_rd[idx] == chk)) hit = 1'b1;
    end
    return hit && (chk != 5'd0) && rst_n;
  endfunction

`ifdef WB_FORWARD_EN
  // Oldest-to-newest scan so newer FIFO entries override; the output stage overrides last.
  function automatic logic [31:0] lookup_data(input logic [4:0] chk);
    logic [31:0]   d;
    logic [AW-1:0] idx;
    d = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rptr + AW'(k);
      if (((AW+1)'(k) < r_count) && (r_rd[idx] == chk)) d = r_data[idx];
    end
    if (r_reg_write && (r_write_reg == chk)) d = r_write_data;
    return (lookup_hit(chk)) ? d : 32'd0;
  endfunction
`endif

  always_comb begin
    bus.rs_pending   = lookup_hit(bus.chk_rs);
    bus.rt_pending   = lookup_hit(bus.chk_rt);
`ifdef WB_FORWARD_EN
    bus.rs_fwd_valid = bus.rs_pending;
    bus.rt_fwd_valid = bus.rt_pending;
    bus.rs_fwd_data  = lookup_data(bus.chk_rs);
    bus.rt_fwd_data  = lookup_data(bus.chk_rt);
`else
    bus.rs_fwd_valid = 1'b0;
    bus.rt_fwd_valid = 1'b0;
    bus.rs_fwd_data  = 32'd0;
    bus.rt_fwd_data  = 32'd0;
`endif
  end

  assign bus.sec_ready  = w_sec_ready;
  assign bus.reg_write  = r_reg_write;
  assign bus.write_reg  = r_write_reg;
  assign bus.write_data = r_write_data;
  assign bus.fifo_count = r_count;

endmodule
